// File: rtl/dekatron_step_ctrl.sv
// Command sequencer for one dekatron counting tube: turns step/load/clear commands into
// guide-pulse or write sequences, tracks the expected glow digit and verifies it against DekOut.
module dekatron_step_ctrl #(
   parameter int PHASE_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       hsClk,
   input  logic       Rst_n,
   input  logic       CmdValid,
   output logic       CmdReady,
   input  logic [1:0] CmdOp,
   input  logic       CmdDir,
   input  logic [3:0] CmdCount,
   input  logic [3:0] CmdData,
   output logic       PulseRight,
   output logic       PulseLeft,
   output logic [9:0] DekIn,
   input  logic [9:0] DekOut,
   output logic [3:0] Position,
   output logic       Carry,
   output logic       Borrow,
   output logic       Busy,
   output logic       Done,
   output logic       Error,
   output logic [2:0] DbgState
);

   // Handshake: a command transfers on a rising edge where CmdValid and CmdReady are both high;
   // CmdReady is high only in IDLE, and CmdValid seen in any other state is dropped.

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_PH1    = 3'd2,
      S_PH2    = 3'd3,
      S_SETTLE = 3'd4,
      S_CHECK  = 3'd5
   } state_t;

   localparam logic [1:0] OP_STEP  = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   state_t      r_state;
   state_t      w_state_next;

   logic [15:0] r_cnt;
   logic [1:0]  r_op;
   logic        r_dir;
   logic [3:0]  r_data;
   logic [3:0]  r_remaining;
   logic        r_continue;

   logic        r_pulse_right;
   logic        r_pulse_left;
   logic [9:0]  r_dek_in;
   logic [3:0]  r_position;
   logic        r_carry;
   logic        r_borrow;
   logic        r_done;
   logic        r_error;
   logic        r_ready;
   logic        r_busy;

   logic        w_accept;
   logic        w_cmd_illegal;
   logic [3:0]  w_load_val;
   logic        w_phase_end;
   logic        w_settle_end;
   logic [3:0]  w_step_pos;
   logic [3:0]  w_target;
   logic [9:0]  w_expect_vec;
   logic        w_match;
   logic [3:0]  w_dek_ones;
   logic [3:0]  w_dek_idx;

   logic        w_dir_nxt;
   logic        w_pr_nxt;
   logic        w_pl_nxt;
   logic [9:0]  w_dek_in_nxt;
   logic [3:0]  w_pos_nxt;
   logic        w_carry_nxt;
   logic        w_borrow_nxt;
   logic        w_done_nxt;
   logic        w_error_nxt;
   logic        w_cont_nxt;
   logic [3:0]  w_rem_nxt;

   assign w_accept      = (r_state == S_IDLE) && CmdValid;
   assign w_cmd_illegal = (CmdOp == OP_RSVD) || ((CmdOp == OP_LOAD) && (CmdData > 4'd9));
   assign w_load_val    = (CmdOp == OP_CLEAR) ? 4'd0 : CmdData;
   assign w_phase_end   = (r_cnt == 16'(PHASE_CYCLES - 1));
   assign w_settle_end  = (r_cnt == 16'(SETTLE_CYCLES - 1));

   assign w_step_pos   = r_dir ? ((r_position == 4'd9) ? 4'd0 : r_position + 4'd1)
                               : ((r_position == 4'd0) ? 4'd9 : r_position - 4'd1);
   assign w_target     = (r_op == OP_STEP) ? w_step_pos : r_data;
   assign w_expect_vec = 10'd1 << w_target;
   assign w_match      = (DekOut == w_expect_vec);

   always_comb begin : dek_decode
      w_dek_ones = 4'd0;
      w_dek_idx  = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (DekOut[i]) begin
            w_dek_ones = w_dek_ones + 4'd1;
            w_dek_idx  = 4'(i);
         end
      end
   end

   always_ff @(posedge hsClk or negedge Rst_n) begin : state_reg
      if (!Rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin : next_state
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (CmdValid) begin
               if (w_cmd_illegal || ((CmdOp == OP_STEP) && (CmdCount == 4'd0)))
                  w_state_next = S_CHECK;
               else if (CmdOp == OP_STEP)
                  w_state_next = S_PH1;
               else
                  w_state_next = S_LOAD;
            end
         end
         S_LOAD:   w_state_next = S_SETTLE;
         S_PH1:    if (w_phase_end)  w_state_next = S_PH2;
         S_PH2:    if (w_phase_end)  w_state_next = S_SETTLE;
         S_SETTLE: if (w_settle_end) w_state_next = S_CHECK;
         S_CHECK:  w_state_next = r_continue ? S_PH1 : S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   // DekOut is captured on the edge that enters CHECK, so Done/Error/Position/Carry are
   // registered and already valid for the whole CHECK cycle.
   always_comb begin : next_outputs
      w_dir_nxt    = w_accept ? CmdDir : r_dir;
      w_pr_nxt     = ((w_state_next == S_PH1) &&  w_dir_nxt) || ((w_state_next == S_PH2) && !w_dir_nxt);
      w_pl_nxt     = ((w_state_next == S_PH1) && !w_dir_nxt) || ((w_state_next == S_PH2) &&  w_dir_nxt);
      w_dek_in_nxt = 10'd0;
      w_pos_nxt    = r_position;
      w_carry_nxt  = 1'b0;
      w_borrow_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      w_error_nxt  = r_error;
      w_cont_nxt   = r_continue;
      w_rem_nxt    = r_remaining;
      if (w_accept) begin
         w_error_nxt = 1'b0;
         w_rem_nxt   = CmdCount;
         w_cont_nxt  = 1'b0;
         if (w_state_next == S_CHECK) begin
            w_done_nxt  = 1'b1;
            w_error_nxt = w_cmd_illegal;
         end
         if (w_state_next == S_LOAD) w_dek_in_nxt = 10'd1 << w_load_val;
      end else if ((r_state == S_SETTLE) && w_settle_end) begin
         w_done_nxt = 1'b1;
         w_cont_nxt = 1'b0;
         if (w_match) begin
            w_pos_nxt = w_target;
            if (r_op == OP_STEP) begin
               w_rem_nxt    = r_remaining - 4'd1;
               w_carry_nxt  =  r_dir && (r_position == 4'd9);
               w_borrow_nxt = !r_dir && (r_position == 4'd0);
               if (r_remaining != 4'd1) begin
                  w_cont_nxt = 1'b1;
                  w_done_nxt = 1'b0;
               end
            end
         end else begin
            w_error_nxt = 1'b1;
            if (w_dek_ones == 4'd1) w_pos_nxt = w_dek_idx;
         end
      end
   end

   always_ff @(posedge hsClk or negedge Rst_n) begin : datapath_reg
      if (!Rst_n) begin
         r_cnt       <= 16'd0;
         r_op        <= OP_STEP;
         r_dir       <= 1'b0;
         r_data      <= 4'd0;
         r_remaining <= 4'd0;
         r_continue  <= 1'b0;
      end else begin
         r_cnt       <= ((w_state_next != r_state) || (r_state == S_IDLE)) ? 16'd0 : r_cnt + 16'd1;
         r_remaining <= w_rem_nxt;
         r_continue  <= w_cont_nxt;
         if (w_accept) begin
            r_op   <= CmdOp;
            r_dir  <= CmdDir;
            r_data <= w_load_val;
         end
      end
   end

   always_ff @(posedge hsClk or negedge Rst_n) begin : output_reg
      if (!Rst_n) begin
         r_pulse_right <= 1'b0;
         r_pulse_left  <= 1'b0;
         r_dek_in      <= 10'd0;
         r_position    <= 4'd0;
         r_carry       <= 1'b0;
         r_borrow      <= 1'b0;
         r_done        <= 1'b0;
         r_error       <= 1'b0;
         r_ready       <= 1'b1;
         r_busy        <= 1'b0;
      end else begin
         r_pulse_right <= w_pr_nxt;
         r_pulse_left  <= w_pl_nxt;
         r_dek_in      <= w_dek_in_nxt;
         r_position    <= w_pos_nxt;
         r_carry       <= w_carry_nxt;
         r_borrow      <= w_borrow_nxt;
         r_done        <= w_done_nxt;
         r_error       <= w_error_nxt;
         r_ready       <= (w_state_next == S_IDLE);
         r_busy        <= (w_state_next != S_IDLE);
      end
   end

   assign PulseRight = r_pulse_right;
   assign PulseLeft  = r_pulse_left;
   assign DekIn      = r_dek_in;
   assign Position   = r_position;
   assign Carry      = r_carry;
   assign Borrow     = r_borrow;
   assign Done       = r_done;
   assign Error      = r_error;
   assign CmdReady   = r_ready;
   assign Busy       = r_busy;
   assign DbgState   = r_state;

endmodule

// File: tb/tb_dekatron_step_ctrl.sv
// Bench for dekatron_step_ctrl: a glow-position tube model plus an arithmetic reference for
// position, latency, carry/borrow and pulse counts of every command.
module tb_dekatron_step_ctrl;

   localparam int P        = 4;
   localparam int S        = 2;
   localparam int STEP_LAT = 2 * P + S + 1;

   logic       hsClk = 1'b0;
   logic       Rst_n;
   logic       CmdValid;
   logic       CmdReady;
   logic [1:0] CmdOp;
   logic       CmdDir;
   logic [3:0] CmdCount;
   logic [3:0] CmdData;
   logic       PulseRight;
   logic       PulseLeft;
   logic [9:0] DekIn;
   logic [9:0] DekOut;
   logic [3:0] Position;
   logic       Carry;
   logic       Borrow;
   logic       Busy;
   logic       Done;
   logic       Error;
   logic [2:0] DbgState;

   int n_checks  = 0;
   int n_errors  = 0;
   int model_pos = 0;

   // tube: glow in thirds of a digit, main cathode k at 3k, guides at 3k+1 (right) and 3k+2 (left)
   int glow       = 0;
   int arrivals   = 0;
   int corrupt_at = 0;
   bit corrupt    = 1'b0;

   dekatron_step_ctrl #(.PHASE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
      .hsClk(hsClk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .CmdOp(CmdOp), .CmdDir(CmdDir), .CmdCount(CmdCount), .CmdData(CmdData),
      .PulseRight(PulseRight), .PulseLeft(PulseLeft), .DekIn(DekIn), .DekOut(DekOut),
      .Position(Position), .Carry(Carry), .Borrow(Borrow), .Busy(Busy),
      .Done(Done), .Error(Error), .DbgState(DbgState)
   );

   always #5 hsClk = ~hsClk;

   function automatic logic [9:0] onehot(input int i);
      logic [9:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   assign DekOut = (corrupt && (arrivals >= corrupt_at)) ? 10'h020 :
                   ((glow % 3 == 0) ? onehot(glow / 3) : 10'h000);

   always @(negedge hsClk) begin : tube_model
      int g;
      int a;
      g = glow;
      a = arrivals;
      if (DekIn != 10'd0) begin
         for (int i = 0; i < 10; i++) if (DekIn[i]) g = 3 * i;
      end else begin
         case (g % 3)
            0: if (PulseRight) g = g + 1; else if (PulseLeft) g = (g + 29) % 30;
            1: if (!PulseRight) begin
                  if (PulseLeft) g = g + 1;
                  else begin g = g - 1; a = a + 1; end
               end
            default: if (!PulseLeft) begin
                  if (PulseRight) g = g - 1;
                  else begin g = (g + 1) % 30; a = a + 1; end
               end
         endcase
      end
      glow     <= g;
      arrivals <= a;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_pulse_right", PulseRight, 0);
      check_eq("rst_pulse_left", PulseLeft, 0);
      check_eq("rst_dek_in", DekIn, 0);
      check_eq("rst_position", Position, 0);
      check_eq("rst_carry", Carry, 0);
      check_eq("rst_borrow", Borrow, 0);
      check_eq("rst_done", Done, 0);
      check_eq("rst_error", Error, 0);
      check_eq("rst_busy", Busy, 0);
      check_eq("rst_ready", CmdReady, 1);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic dir, input int cnt, input int data,
                          input bit corrupt_en, input bit hold, input int post);
      int k, lat_exp, steps, matched, exp_pos, exp_carry, exp_borrow, wait_n;
      int pr_cyc, pl_cyc, both_cyc, dekin_cyc, rdy_bad, carry_n, borrow_n, post_pulses;
      bit illegal, done_seen;
      wait_n = 0;
      while (!CmdReady && wait_n < 100) begin
         @(posedge hsClk); #1;
         wait_n++;
      end
      check_eq("ready_before_cmd", CmdReady, 1);
      CmdOp = op; CmdDir = dir; CmdCount = cnt[3:0]; CmdData = data[3:0]; CmdValid = 1'b1;
      corrupt_at = arrivals + 2;
      corrupt    = corrupt_en;
      @(posedge hsClk); #1;
      if (!hold) CmdValid = 1'b0;

      illegal = (op == 2'b11) || ((op == 2'b01) && (data > 9));
      steps   = 0;
      matched = 0;
      if (illegal) begin
         lat_exp = 1;
         exp_pos = model_pos;
      end else if (op == 2'b00) begin
         steps   = corrupt_en ? 2 : cnt;
         matched = corrupt_en ? 1 : cnt;
         lat_exp = (cnt == 0) ? 1 : steps * STEP_LAT;
         exp_pos = dir ? (model_pos + steps) % 10 : ((model_pos - steps) % 10 + 10) % 10;
         if (corrupt_en) exp_pos = 5;
      end else begin
         lat_exp = S + 2;
         exp_pos = (op == 2'b10) ? 0 : data;
      end
      exp_carry  = (op == 2'b00 &&  dir) ? (model_pos + matched) / 10 : 0;
      exp_borrow = (op == 2'b00 && !dir) ? (9 - model_pos + matched) / 10 : 0;

      k = 1; done_seen = 0;
      pr_cyc = 0; pl_cyc = 0; both_cyc = 0; dekin_cyc = 0; rdy_bad = 0; carry_n = 0; borrow_n = 0;
      while (k <= 400) begin
         if (PulseRight) pr_cyc++;
         if (PulseLeft) pl_cyc++;
         if (PulseRight && PulseLeft) both_cyc++;
         if (DekIn != 10'd0) dekin_cyc++;
         if (CmdReady || !Busy) rdy_bad++;
         if (Carry) carry_n++;
         if (Borrow) borrow_n++;
         if (k == 1 && op == 2'b00 && cnt != 0 && !illegal) begin
            check_eq("first_pulse_right", PulseRight, dir);
            check_eq("first_pulse_left", PulseLeft, !dir);
         end
         if (Done) begin
            done_seen = 1;
            break;
         end
         @(posedge hsClk); #1;
         k++;
      end
      if (hold) CmdValid = 1'b0;
      check_eq("done_seen", done_seen, 1);
      check_eq("latency", k, lat_exp);
      check_eq("position", Position, exp_pos);
      check_eq("error", Error, (illegal || corrupt_en) ? 1 : 0);
      check_eq("carry_count", carry_n, exp_carry);
      check_eq("borrow_count", borrow_n, exp_borrow);
      check_eq("right_cycles", pr_cyc, steps * P);
      check_eq("left_cycles", pl_cyc, steps * P);
      check_eq("pulse_overlap", both_cyc, 0);
      check_eq("dekin_cycles", dekin_cyc, (!illegal && op != 2'b00) ? 1 : 0);
      check_eq("busy_ready", rdy_bad, 0);
      if (!illegal && !corrupt_en) check_eq("dek_out", DekOut, onehot(exp_pos));

      post_pulses = 0;
      for (int j = 1; j <= post; j++) begin
         @(posedge hsClk); #1;
         if (j == 1) begin
            check_eq("ready_after_done", CmdReady, 1);
            check_eq("busy_after_done", Busy, 0);
            check_eq("done_one_cycle", Done, 0);
         end
         if (PulseRight || PulseLeft) post_pulses++;
      end
      check_eq("pulses_after_done", post_pulses, 0);
      model_pos = exp_pos;
      corrupt   = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int r;
      Rst_n = 1'b0; CmdValid = 1'b0; CmdOp = 2'b00; CmdDir = 1'b0; CmdCount = 4'd0; CmdData = 4'd0;
      repeat (3) @(posedge hsClk);
      #1;
      check_reset_outputs();
      @(negedge hsClk); Rst_n = 1'b1;
      @(posedge hsClk); #1;

      run_cmd(2'b10, 1'b0, 0, 0, 0, 0, 2);    // clear
      run_cmd(2'b00, 1'b1, 3, 0, 0, 0, 2);    // +3 from 0
      run_cmd(2'b01, 1'b0, 0, 8, 0, 0, 2);    // load 8
      run_cmd(2'b00, 1'b1, 3, 0, 0, 0, 2);    // 8 -> 1, one carry
      run_cmd(2'b00, 1'b0, 2, 0, 0, 0, 2);    // 1 -> 9, one borrow
      run_cmd(2'b01, 1'b0, 0, 12, 0, 0, 2);   // illegal load
      run_cmd(2'b10, 1'b0, 0, 0, 0, 0, 2);    // clears Error
      run_cmd(2'b00, 1'b1, 5, 0, 1, 0, 12);   // second check sees 10'h020
      run_cmd(2'b10, 1'b0, 0, 0, 0, 0, 2);
      run_cmd(2'b00, 1'b1, 4, 0, 0, 1, 3);    // CmdValid held through busy
      run_cmd(2'b11, 1'b1, 3, 0, 0, 0, 2);    // reserved op
      run_cmd(2'b00, 1'b0, 0, 0, 0, 0, 2);    // zero-count step

      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 5)      run_cmd(2'b00, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 0, 0, 0, 2);
         else if (r <= 7) run_cmd(2'b01, 1'b0, 0, $urandom_range(0, 15), 0, 0, 2);
         else if (r == 8) run_cmd(2'b10, 1'b0, 0, $urandom_range(0, 15), 0, 0, 2);
         else             run_cmd(2'b11, 1'($urandom_range(0, 1)), $urandom_range(0, 15), 0, 0, 0, 2);
      end

      CmdOp = 2'b00; CmdDir = 1'b1; CmdCount = 4'd3; CmdValid = 1'b1;
      @(posedge hsClk); #1;
      CmdValid = 1'b0;
      repeat (6) @(posedge hsClk);
      #1;
      Rst_n = 1'b0;
      #1;
      check_reset_outputs();
      repeat (3) @(posedge hsClk);
      #1;
      check_eq("rst_hold_busy", Busy, 0);
      check_eq("rst_hold_pulses", {PulseRight, PulseLeft}, 0);
      @(negedge hsClk); Rst_n = 1'b1;
      model_pos = 0;
      run_cmd(2'b10, 1'b0, 0, 0, 0, 0, 2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
